// File: rtl/cpu_pkg.sv
// Shared types and widths for the 16-bit CPU front end.
// Contents: address/data widths, fetch FSM state encoding and the
// fetch buffer entry payload ({pc, instr}).
package cpu_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: ROM req/ack port, decode valid/ready port and
// the redirect input from execute.
// Modports: master = fetch unit side, slave = ROM/decode/execute side.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic              jump_valid;
  logic [ADDR_W-1:0] jump_addr;
  logic              rom_req;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ack;
  logic [DATA_W-1:0] rom_data;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;

  modport master (
    input  jump_valid, jump_addr, rom_ack, rom_data, instr_ready,
    output rom_req, rom_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output jump_valid, jump_addr, rom_ack, rom_data, instr_ready,
    input  rom_req, rom_addr, instr_valid, instr, instr_pc
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: synchronous DEPTH-entry FIFO of fetch_entry_t.
// Ports: clk, reset (sync, active-high), push/push_data, pop, flush,
// head (entry at read pointer), count, full, empty.
// Flush wins over push; pop alongside flush is harmless.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Pointer/count next state; pointers wrap naturally since DEPTH is 2^n.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage is cleared on reset so the head reads as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end. Owns the fetch PC, issues ROM
// reads over req/ack, buffers returned instructions and presents them to
// decode on valid/ready. Redirects from execute flush buffered and
// in-flight fetches.
// Ports: clk, reset (sync, active-high), bus (fetch_unit_if.master).
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       DEPTH      = 2,
  parameter logic [ADDR_W-1:0] RESET_ADDR = 16'h0000
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              rom_req_q, rom_req_d;
  logic [ADDR_W-1:0] pc_inc;
  logic              ack, pop, push, flush, full, empty;
  logic [CNT_W-1:0]  count, count_after;
  fetch_entry_t      push_data, head;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign bus.rom_req     = rom_req_q;
  assign bus.rom_addr    = rom_addr_q;
  assign bus.instr_valid = !empty;
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;

  // Fetch sequencing: IDLE issues, REQ waits for data, DROP swallows the
  // response of a request that a jump made stale.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    rom_addr_d  = rom_addr_q;
    rom_req_d   = rom_req_q;
    ack         = rom_req_q && bus.rom_ack;
    pop         = !empty && bus.instr_ready;
    flush       = bus.jump_valid;
    push        = 1'b0;
    pc_inc      = fetch_pc_q + ADDR_W'(1);
    push_data   = '{pc: fetch_pc_q, instr: bus.rom_data};
    count_after = count - CNT_W'(pop) + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (bus.jump_valid) begin
          state_d    = REQ;
          fetch_pc_d = bus.jump_addr;
          rom_addr_d = bus.jump_addr;
          rom_req_d  = 1'b1;
        end else if (!full) begin
          state_d    = REQ;
          rom_addr_d = fetch_pc_q;
          rom_req_d  = 1'b1;
        end
      end
      REQ: begin
        if (ack && bus.jump_valid) begin
          fetch_pc_d = bus.jump_addr;
          rom_addr_d = bus.jump_addr;
        end else if (ack) begin
          push       = 1'b1;
          fetch_pc_d = pc_inc;
          rom_addr_d = pc_inc;
          // Keep requesting only if the slot survives this write.
          if (count_after >= CNT_W'(DEPTH)) begin
            state_d   = IDLE;
            rom_req_d = 1'b0;
          end
        end else if (bus.jump_valid) begin
          // Address must stay put until the pending ack arrives.
          state_d    = DROP;
          fetch_pc_d = bus.jump_addr;
        end
      end
      DROP: begin
        if (ack && bus.jump_valid) begin
          state_d    = REQ;
          fetch_pc_d = bus.jump_addr;
          rom_addr_d = bus.jump_addr;
        end else if (ack) begin
          rom_addr_d = fetch_pc_q;
          if (full) begin
            state_d   = IDLE;
            rom_req_d = 1'b0;
          end else begin
            state_d = REQ;
          end
        end else if (bus.jump_valid) begin
          fetch_pc_d = bus.jump_addr;
        end
      end
      default: begin
        state_d   = IDLE;
        rom_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_ADDR;
      rom_addr_q <= RESET_ADDR;
      rom_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rom_addr_q <= rom_addr_d;
      rom_req_q  <= rom_req_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based behavioural model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.DEPTH(DEPTH), .RESET_ADDR(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int passed = 0;
  int total  = 0;

  // ROM: data = addr ^ A5A5; ack either tied high or after 3 request cycles.
  logic       tie_ack  = 1'b1;
  logic       lat_mode = 1'b0;
  logic [1:0] lat_cnt  = 2'd0;
  assign bus.rom_data = bus.rom_addr ^ 16'hA5A5;
  assign bus.rom_ack  = tie_ack || (lat_mode && bus.rom_req && lat_cnt == 2'd2);
  always @(posedge clk) lat_cnt <= (bus.rom_req && !bus.rom_ack) ? lat_cnt + 2'd1 : 2'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
  endtask

  // Model: buffered entries, fetch PC, current request and whether its
  // response is stale. Compared at negedge, then advanced to the state
  // expected after the coming posedge.
  logic [31:0] m_q [$];
  logic [15:0] m_pc, m_addr;
  bit          m_req, m_stale, m_init;

  initial begin
    int sz0;
    bit ack;
    m_init = 1'b0;
    forever begin
      @(negedge clk);
      if (m_init) begin
        chk("m_rom_req", 32'(bus.rom_req), 32'(m_req));
        if (m_req) chk("m_rom_addr", 32'(bus.rom_addr), 32'(m_addr));
        chk("m_instr_valid", 32'(bus.instr_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
          chk("m_instr_pc", 32'(bus.instr_pc), 32'(m_q[0][31:16]));
          chk("m_instr", 32'(bus.instr), 32'(m_q[0][15:0]));
        end
      end
      if (reset) begin
        m_q.delete();
        m_pc = 16'h0000; m_addr = 16'h0000;
        m_req = 1'b0; m_stale = 1'b0; m_init = 1'b1;
      end else if (m_init) begin
        sz0 = m_q.size();
        ack = m_req && bus.rom_ack;
        if (sz0 != 0 && bus.instr_ready) void'(m_q.pop_front());
        if (bus.jump_valid) begin
          m_q.delete();
          m_pc = bus.jump_addr;
          if (m_req && !ack) m_stale = 1'b1;
          else begin m_req = 1'b1; m_addr = m_pc; m_stale = 1'b0; end
        end else if (ack) begin
          if (!m_stale) begin
            m_q.push_back({m_pc, m_pc ^ 16'hA5A5});
            m_pc = m_pc + 16'd1;
          end
          m_stale = 1'b0;
          m_addr = m_pc;
          m_req = (m_q.size() < DEPTH);
        end else if (!m_req && sz0 < DEPTH) begin
          m_req = 1'b1;
          m_addr = m_pc;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  initial begin
    bit found, seen7;
    int acks, n;
    logic [15:0] seq [4];
    reset = 1'b1;
    bus.jump_valid = 1'b0;
    bus.jump_addr = 16'h0000;
    bus.instr_ready = 1'b1;

    // Reset then streaming run.
    apply_reset();
    chk("rst_rom_req", 32'(bus.rom_req), 32'd0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'h0000);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", 32'(bus.instr), 32'h0000);
    chk("rst_instr_pc", 32'(bus.instr_pc), 32'h0000);
    reset = 1'b0;
    step();
    chk("run_req_rise", 32'(bus.rom_req), 32'd1);
    chk("run_addr0", 32'(bus.rom_addr), 32'h0000);
    chk("run_valid_before", 32'(bus.instr_valid), 32'd0);
    step();
    chk("run_valid0", 32'(bus.instr_valid), 32'd1);
    chk("run_pc0", 32'(bus.instr_pc), 32'h0000);
    chk("run_instr0", 32'(bus.instr), 32'hA5A5);
    step();
    chk("run_pc1", 32'(bus.instr_pc), 32'h0001);
    chk("run_instr1", 32'(bus.instr), 32'hA5A4);
    step();
    chk("run_pc2", 32'(bus.instr_pc), 32'h0002);
    chk("run_instr2", 32'(bus.instr), 32'hA5A7);
    repeat (5) step();

    // Backpressure.
    bus.instr_ready = 1'b0;
    apply_reset();
    reset = 1'b0;
    acks = 0;
    repeat (10) begin
      step();
      if (bus.rom_req && bus.rom_ack) acks++;
    end
    chk("bp_acks", 32'(acks), 32'd2);
    chk("bp_req_low", 32'(bus.rom_req), 32'd0);
    chk("bp_head_pc", 32'(bus.instr_pc), 32'h0000);
    bus.instr_ready = 1'b1;
    step();
    chk("bp_drain_pc1", 32'(bus.instr_pc), 32'h0001);
    chk("bp_still_idle", 32'(bus.rom_req), 32'd0);
    step();
    chk("bp_resume_req", 32'(bus.rom_req), 32'd1);
    chk("bp_resume_addr", 32'(bus.rom_addr), 32'h0002);
    step();
    chk("bp_resume_pc2", 32'(bus.instr_pc), 32'h0002);

    // Jump with FIFO holding pcs 4,5 and nothing outstanding.
    apply_reset();
    reset = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      if (bus.instr_valid && bus.instr_pc == 16'h0004) found = 1'b1;
    end
    chk("j1_reach_pc4", 32'(found), 32'd1);
    bus.instr_ready = 1'b0;
    step();
    chk("j1_full_idle", 32'(bus.rom_req), 32'd0);
    chk("j1_head_pc4", 32'(bus.instr_pc), 32'h0004);
    bus.jump_valid = 1'b1;
    bus.jump_addr = 16'h0100;
    step();
    bus.jump_valid = 1'b0;
    chk("j1_flushed", 32'(bus.instr_valid), 32'd0);
    chk("j1_req", 32'(bus.rom_req), 32'd1);
    chk("j1_addr", 32'(bus.rom_addr), 32'h0100);
    bus.instr_ready = 1'b1;
    step();
    chk("j1_first_pc", 32'(bus.instr_pc), 32'h0100);
    chk("j1_first_instr", 32'(bus.instr), 32'hA4A5);

    // Jump while a slow request for addr 7 is outstanding.
    tie_ack = 1'b0;
    lat_mode = 1'b1;
    apply_reset();
    reset = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (bus.rom_req && bus.rom_addr == 16'h0007) found = 1'b1;
    end
    chk("j2_reach_addr7", 32'(found), 32'd1);
    step();
    bus.jump_valid = 1'b1;
    bus.jump_addr = 16'h0200;
    step();
    bus.jump_valid = 1'b0;
    chk("j2_hold_req", 32'(bus.rom_req), 32'd1);
    chk("j2_hold_addr7", 32'(bus.rom_addr), 32'h0007);
    step();
    chk("j2_new_req", 32'(bus.rom_req), 32'd1);
    chk("j2_new_addr", 32'(bus.rom_addr), 32'h0200);
    found = 1'b0;
    seen7 = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.instr_valid && bus.instr_pc == 16'h0007) seen7 = 1'b1;
      if (bus.instr_valid) found = 1'b1;
      else step();
    end
    chk("j2_got_instr", 32'(found), 32'd1);
    chk("j2_stale_hidden", 32'(seen7), 32'd0);
    chk("j2_first_pc", 32'(bus.instr_pc), 32'h0200);
    chk("j2_first_instr", 32'(bus.instr), 32'hA7A5);

    // PC wrap-around.
    tie_ack = 1'b1;
    lat_mode = 1'b0;
    apply_reset();
    reset = 1'b0;
    bus.jump_valid = 1'b1;
    bus.jump_addr = 16'hFFFE;
    step();
    bus.jump_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      step();
      if (bus.instr_valid) begin
        seq[n] = bus.instr_pc;
        n++;
      end
    end
    chk("wrap_count", 32'(n), 32'd4);
    chk("wrap_pc0", 32'(seq[0]), 32'hFFFE);
    chk("wrap_pc1", 32'(seq[1]), 32'hFFFF);
    chk("wrap_pc2", 32'(seq[2]), 32'h0000);
    chk("wrap_pc3", 32'(seq[3]), 32'h0001);

    // Reset mid-request with the ack landing in the reset cycle.
    tie_ack = 1'b0;
    lat_mode = 1'b1;
    bus.instr_ready = 1'b0;
    apply_reset();
    reset = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      if (bus.rom_req && bus.rom_addr == 16'h0001 && lat_cnt == 2'd2) found = 1'b1;
    end
    chk("mr_reach_ack", 32'(found), 32'd1);
    chk("mr_pre_valid", 32'(bus.instr_valid), 32'd1);
    reset = 1'b1;
    step();
    chk("mr_req_low", 32'(bus.rom_req), 32'd0);
    chk("mr_valid_low", 32'(bus.instr_valid), 32'd0);
    reset = 1'b0;
    bus.instr_ready = 1'b1;
    step();
    chk("mr_restart_req", 32'(bus.rom_req), 32'd1);
    chk("mr_restart_addr", 32'(bus.rom_addr), 32'h0000);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus.instr_valid) found = 1'b1;
    end
    chk("mr_got_instr", 32'(found), 32'd1);
    chk("mr_first_pc", 32'(bus.instr_pc), 32'h0000);
    repeat (3) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end for the 16-bit CPU. Owns the fetch program counter and issues ROM read requests over a req/ack handshake.
- Buffers returned instructions in a small FIFO and presents them to decode on a valid/ready interface.
- Accepts redirect (jump) requests from execute, which flush buffered and in-flight fetches.

Parameters:
- ADDR_W, 16, width of fetch address / PC
- DATA_W, 16, instruction width
- DEPTH, 2, instruction FIFO entries (power of two, >=2)
- RESET_ADDR, 16'h0000, fetch PC value after reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- jump_valid  in  1  redirect request from execute, single-cycle pulse
- jump_addr  in  ADDR_W  redirect target
- rom_req  out  1  ROM read request
- rom_addr  out  ADDR_W  ROM read address, stable while rom_req high and unacked
- rom_ack  in  1  ROM read complete; rom_data valid in this cycle; only meaningful while rom_req high
- rom_data  in  DATA_W  ROM read data
- instr_valid  out  1  head FIFO entry valid
- instr  out  DATA_W  head instruction
- instr_pc  out  ADDR_W  address the head instruction was fetched from
- instr_ready  in  1  decode accepts head entry

Behaviour:
- Reset:
  - fetch_pc=RESET_ADDR, FIFO empty, state IDLE.
  - rom_req=0, rom_addr=RESET_ADDR, instr_valid=0, instr=0, instr_pc=0.
  - Reset overrides all other inputs, including mid-request; a pending ROM ack is ignored.
- States:
  - IDLE: no request outstanding.
  - REQ: rom_req=1, rom_addr=fetch_pc.
  - DROP: rom_req=1, waiting to discard a stale response.
- Issue rule: a request may be issued when count + outstanding < DEPTH, where outstanding counts a request issued but not yet acked (0 or 1). At most one request is outstanding.
- IDLE -> REQ when the issue rule holds and no jump is present.
- In REQ, on rom_ack:
  - Write {fetch_pc, rom_data} to the FIFO tail.
  - fetch_pc <= fetch_pc+1, modulo 2^ADDR_W, so 16'hFFFF wraps to 16'h0000.
  - Stay in REQ with the new address if space remains after the write, counting a same-cycle pop. Otherwise go to IDLE.
- ack may arrive in the same cycle rom_req rises. Sustained throughput is 1 instruction per cycle when ack is tied high and decode is always ready.
- Fetch latency: rom_ack to instr_valid is 1 cycle. There is no combinational bypass from rom_data to instr.
- Output: instr_valid = FIFO non-empty. instr and instr_pc show the head entry. Pop when instr_valid && instr_ready.
- Full FIFO: no new request is issued; rom_req drops after the ack that fills the last slot.
- Empty FIFO: instr_valid=0; instr_ready is ignored.
- Jump, all cases:
  - The FIFO is flushed at the clock edge.
  - fetch_pc <= jump_addr.
  - A same-cycle pop counts as consumed by decode; the flush removes the remaining entries.
  - Any same-cycle rom_ack write is discarded.
- Jump, with no request outstanding, or with rom_ack in the same cycle: next state REQ with rom_addr=jump_addr on the following cycle.
- Jump while in REQ without ack: next state DROP. rom_req stays high and rom_addr keeps the old address, preserving handshake stability.
  - The next ack is discarded.
  - Then go to REQ at jump_addr. There is no idle cycle if the issue rule holds; otherwise go to IDLE.
- Jump while in DROP: update fetch_pc to the newest jump_addr and stay in DROP.
- Back-to-back jumps: the last one wins.
- FIFO count and pointers use $clog2(DEPTH)+1 bits for count. Pointers wrap at DEPTH.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W and DATA_W constants.
  - An enum fetch_state_t {IDLE, REQ, DROP}.
  - A struct fetch_entry_t {pc, instr}.
- One sub-module: fetch_fifo, a synchronous DEPTH-entry FIFO of fetch_entry_t with push, pop, flush, count, full and empty.
  - flush has priority over push.
  - pop and flush in the same cycle are allowed.

Test Plan:
- Reset then run: reset 2 cycles, rom_ack tied 1, ROM returns data=addr^16'hA5A5, instr_ready=1.
  - rom_req rises in the first post-reset cycle with rom_addr=0.
  - instr_valid one cycle after the first ack.
  - instr_pc increments 0,1,2,… each cycle, with instr matching.
- Backpressure: instr_ready=0 for 10 cycles.
  - Exactly DEPTH=2 acks are accepted (pc 0,1).
  - rom_req is low after the second ack.
  - On releasing ready, entries drain in order and fetching resumes at addr 2.
- Jump with FIFO holding pcs 4,5 and no outstanding request, jump_addr=16'h0100.
  - Next cycle instr_valid=0, rom_addr=16'h0100.
  - The first delivered instr_pc is 16'h0100.
- Jump during outstanding request: ROM with 3-cycle ack latency, jump_addr=16'h0200 asserted 1 cycle after rom_req for addr 7.
  - rom_addr stays 7 until ack, and that data is never presented.
  - The next rom_addr is 16'h0200.
- Wrap-around: jump to 16'hFFFE, ready=1.
  - instr_pc sequence FFFE, FFFF, 0000, 0001.
- Mid-operation reset: assert reset while rom_req=1 awaiting ack, with ack arriving in the reset cycle.
  - Next cycle rom_req=0, instr_valid=0.
  - Fetch restarts at RESET_ADDR.
